// File: rtl/free_list_mw_if.sv
// Dispatch/retire/recovery bundle for the multi-way free list.
// The master side drives requests and returned tags; the slave side is the free list.
interface free_list_mw_if #(
  parameter int PREG_NUM = 64,
  parameter int ARCH_NUM = 32,
  parameter int WAYS     = 2
);
  localparam int DEPTH  = PREG_NUM - ARCH_NUM;
  localparam int PREG_W = $clog2(PREG_NUM);
  localparam int PTR_W  = $clog2(DEPTH);

  logic [WAYS-1:0]        dispatch_req_i;
  logic [WAYS-1:0]        retire_en_i;
  logic [WAYS*PREG_W-1:0] retire_preg_i;
  logic                   recover_en_i;
  logic [PTR_W-1:0]       rc_head_i;
  logic [WAYS*PREG_W-1:0] free_preg_o;
  logic [WAYS-1:0]        free_preg_vld_o;
  logic [PTR_W-1:0]       head_o;
  logic [PTR_W:0]         count_o;
  logic                   stall_o;

  modport master (
    output dispatch_req_i, retire_en_i, retire_preg_i, recover_en_i, rc_head_i,
    input  free_preg_o, free_preg_vld_o, head_o, count_o, stall_o
  );

  modport slave (
    input  dispatch_req_i, retire_en_i, retire_preg_i, recover_en_i, rc_head_i,
    output free_preg_o, free_preg_vld_o, head_o, count_o, stall_o
  );
endinterface

// File: rtl/free_list_mw.sv
// Multi-way circular free list of physical register tags with branch recovery.
// Define FL_BYPASS_EN to forward same-cycle retired tags to lanes the list cannot serve.
module free_list_mw #(
  parameter int PREG_NUM = 64,
  parameter int ARCH_NUM = 32,
  parameter int WAYS     = 2
) (
  input  logic          clk,
  input  logic          rst,
  free_list_mw_if.slave fl_if
);
  localparam int DEPTH  = PREG_NUM - ARCH_NUM;
  localparam int PREG_W = $clog2(PREG_NUM);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [PREG_W-1:0] r_fl [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [PREG_W-1:0] w_ret_tag [WAYS];
  logic [PREG_W-1:0] w_out_tag [WAYS];
  logic [WAYS-1:0]   w_grant_fl;
  logic [WAYS-1:0]   w_grant_byp;
  logic [WAYS-1:0]   w_vld;
  logic [PTR_W-1:0]  w_rc_ret;
  int                w_nret;
  int                w_ngrant;
  int                w_nbyp;
  int                w_cnt;

  // Active retire lanes packed in lane order: k-th active lane lands in slot k.
  always_comb begin
    w_nret = 0;
    for (int k = 0; k < WAYS; k++) w_ret_tag[k] = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (fl_if.retire_en_i[i]) begin
        for (int k = 0; k < WAYS; k++) begin
          if (k == w_nret) w_ret_tag[k] = fl_if.retire_preg_i[i*PREG_W +: PREG_W];
        end
        w_nret = w_nret + 1;
      end
    end
  end

  always_comb begin
    w_cnt       = int'(r_count);
    w_ngrant    = 0;
    w_nbyp      = 0;
    w_grant_fl  = '0;
    w_grant_byp = '0;
    for (int i = 0; i < WAYS; i++) w_out_tag[i] = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (fl_if.dispatch_req_i[i] && !fl_if.recover_en_i) begin
        if (i < w_cnt) begin
          w_grant_fl[i] = 1'b1;
          w_out_tag[i]  = r_fl[r_head + PTR_W'(i)];
          w_ngrant      = w_ngrant + 1;
        end
`ifdef FL_BYPASS_EN
        else if ((i - w_cnt) < w_nret) begin
          w_grant_byp[i] = 1'b1;
          for (int k = 0; k < WAYS; k++) begin
            if (k == (i - w_cnt)) w_out_tag[i] = w_ret_tag[k];
          end
          w_nbyp = w_nbyp + 1;
        end
`endif
      end
    end
  end

  assign w_vld    = w_grant_fl | w_grant_byp;
  assign w_rc_ret = r_head - fl_if.rc_head_i;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_lane
      assign fl_if.free_preg_o[gi*PREG_W +: PREG_W] = w_out_tag[gi];
    end
  endgenerate

  assign fl_if.free_preg_vld_o = w_vld;
  assign fl_if.stall_o         = |(fl_if.dispatch_req_i & ~w_vld);
  assign fl_if.head_o          = r_head;
  assign fl_if.count_o         = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= CNT_W'(DEPTH);
      for (int i = 0; i < DEPTH; i++) r_fl[i] <= PREG_W'(ARCH_NUM + i);
    end else begin
      // Bypassed tags occupy the first compacted slots and never enter the list.
      for (int k = 0; k < WAYS; k++) begin
        if (k >= w_nbyp && k < w_nret) r_fl[r_tail + PTR_W'(k - w_nbyp)] <= w_ret_tag[k];
      end
      r_tail <= r_tail + PTR_W'(w_nret - w_nbyp);
      if (fl_if.recover_en_i) begin
        r_head  <= fl_if.rc_head_i;
        r_count <= r_count + {1'b0, w_rc_ret} + CNT_W'(w_nret);
      end else begin
        r_head  <= r_head + PTR_W'(w_ngrant);
        r_count <= r_count + CNT_W'(w_nret) - CNT_W'(w_ngrant + w_nbyp);
      end
    end
  end

`ifdef DEBUG
  always_ff @(posedge clk) begin
    if (!rst) assert (int'(r_count) + w_nret <= DEPTH);
  end
`endif
endmodule

// File: tb/tb_free_list_mw.sv
// Table-driven check of free_list_mw: drain, empty, same-cycle retire, wrap,
// recovery and mid-operation reset, with hand-computed expectations.
module tb_free_list_mw;
  localparam int PREG_NUM = 64;
  localparam int ARCH_NUM = 32;
  localparam int WAYS     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  free_list_mw_if #(.PREG_NUM(PREG_NUM), .ARCH_NUM(ARCH_NUM), .WAYS(WAYS)) fl_if ();

  free_list_mw #(.PREG_NUM(PREG_NUM), .ARCH_NUM(ARCH_NUM), .WAYS(WAYS)) dut (
    .clk  (clk),
    .rst  (rst),
    .fl_if(fl_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_v;
    logic [1:0] req;
    logic [1:0] ren;
    logic [5:0] rt0;
    logic [5:0] rt1;
    logic       rec;
    logic [4:0] rch;
    logic [1:0] evld;
    logic [5:0] e0;
    logic [5:0] e1;
    logic       est;
    logic [4:0] ehead;
    logic [5:0] ecnt;
  } vec_t;

  vec_t vecs [64];
  int   nv    = 0;
  int   total = 0;
  int   bad   = 0;
  int   row   = -1;

  task automatic add(input logic r, input logic [1:0] req, input logic [1:0] ren,
                     input logic [5:0] rt0, input logic [5:0] rt1, input logic rec,
                     input logic [4:0] rch, input logic [1:0] evld, input logic [5:0] e0,
                     input logic [5:0] e1, input logic est, input logic [4:0] eh,
                     input logic [5:0] ec);
    vecs[nv].rst_v = r;   vecs[nv].req   = req;  vecs[nv].ren  = ren;
    vecs[nv].rt0   = rt0; vecs[nv].rt1   = rt1;  vecs[nv].rec  = rec;
    vecs[nv].rch   = rch; vecs[nv].evld  = evld; vecs[nv].e0   = e0;
    vecs[nv].e1    = e1;  vecs[nv].est   = est;  vecs[nv].ehead = eh;
    vecs[nv].ecnt  = ec;
    nv++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d actual=%0d required=%0d", name, row, act, exp);
    end
  endtask

  task automatic check_outputs(input logic [1:0] evld, input logic [5:0] e0, input logic [5:0] e1,
                               input logic est, input logic [4:0] eh, input logic [5:0] ec);
    check("vld",   32'(fl_if.free_preg_vld_o), 32'(evld));
    check("lane0", 32'(fl_if.free_preg_o[5:0]), 32'(e0));
    check("lane1", 32'(fl_if.free_preg_o[11:6]), 32'(e1));
    check("stall", 32'(fl_if.stall_o), 32'(est));
    check("head",  32'(fl_if.head_o), 32'(eh));
    check("count", 32'(fl_if.count_o), 32'(ec));
    $display("row=%0d req=%b ren=%b rec=%b vld=%b tags=%0d,%0d stall=%b head=%0d count=%0d",
             row, fl_if.dispatch_req_i, fl_if.retire_en_i, fl_if.recover_en_i,
             fl_if.free_preg_vld_o, fl_if.free_preg_o[5:0], fl_if.free_preg_o[11:6],
             fl_if.stall_o, fl_if.head_o, fl_if.count_o);
  endtask

  initial begin
    // Phase A: drain to empty, then empty-list retire behaviour.
    add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 6'd32, 6'd33, 0, 5'd0, 6'd32);
    for (int k = 1; k <= 14; k++)
      add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 6'(32 + 2*k), 6'(33 + 2*k), 0, 5'(2*k), 6'(32 - 2*k));
    add(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 6'd62, 6'd0, 0, 5'd30, 6'd2);
    add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 6'd63, 6'd0, 1, 5'd31, 6'd1);
    add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 6'd0,  6'd0, 1, 5'd0,  6'd0);
`ifdef FL_BYPASS_EN
    add(0, 2'b11, 2'b11, 6'd40, 6'd41, 0, 0, 2'b11, 6'd40, 6'd41, 0, 5'd0, 6'd0);
    add(0, 2'b00, 2'b10, 6'd7,  6'd50, 0, 0, 2'b00, 6'd0,  6'd0,  0, 5'd0, 6'd0);
    add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 6'd50, 6'd0, 1, 5'd0, 6'd1);
    add(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 6'd0,  6'd0, 1, 5'd1, 6'd0);
`else
    add(0, 2'b11, 2'b11, 6'd40, 6'd41, 0, 0, 2'b00, 6'd0,  6'd0,  1, 5'd0, 6'd0);
    add(0, 2'b00, 2'b10, 6'd7,  6'd50, 0, 0, 2'b00, 6'd0,  6'd0,  0, 5'd0, 6'd2);
    add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 6'd40, 6'd41, 0, 5'd0, 6'd3);
    add(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 6'd50, 6'd0,  0, 5'd2, 6'd1);
`endif
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Phase B: retire while dispatching, pointer wrap, checkpoint recovery.
    for (int k = 0; k <= 14; k++)
      add(0, 2'b11, 2'b11, 6'(2*k), 6'(2*k + 1), 0, 0, 2'b11, 6'(32 + 2*k), 6'(33 + 2*k), 0, 5'(2*k), 6'd32);
    add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 6'd62, 6'd63, 0, 5'd30, 6'd32);
    add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 6'd0,  6'd1,  0, 5'd0,  6'd30);
    add(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 6'd2,  6'd0,  0, 5'd2,  6'd28);
    add(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 6'd3,  6'd0,  0, 5'd3,  6'd27);
    add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 6'd4,  6'd5,  0, 5'd4,  6'd26);
    add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 6'd6,  6'd7,  0, 5'd6,  6'd24);
    add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 6'd8,  6'd9,  0, 5'd8,  6'd22);
    add(0, 2'b11, 2'b01, 6'd45, 6'd0, 1, 5'd4, 2'b00, 6'd0, 6'd0, 1, 5'd10, 6'd20);
    add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 6'd4, 6'd5, 0, 5'd4, 6'd27);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Phase C: list contents restored by the mid-run reset.
    add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 6'd32, 6'd33, 0, 5'd0, 6'd32);

    fl_if.dispatch_req_i = '0;
    fl_if.retire_en_i    = '0;
    fl_if.retire_preg_i  = '0;
    fl_if.recover_en_i   = 1'b0;
    fl_if.rc_head_i      = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs(2'b00, 6'd0, 6'd0, 1'b0, 5'd0, 6'd32);

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      row                  = i;
      rst                  = vecs[i].rst_v;
      fl_if.dispatch_req_i = vecs[i].req;
      fl_if.retire_en_i    = vecs[i].ren;
      fl_if.retire_preg_i  = {vecs[i].rt1, vecs[i].rt0};
      fl_if.recover_en_i   = vecs[i].rec;
      fl_if.rc_head_i      = vecs[i].rch;
      #1;
      if (!vecs[i].rst_v)
        check_outputs(vecs[i].evld, vecs[i].e0, vecs[i].e1, vecs[i].est, vecs[i].ehead, vecs[i].ecnt);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
